// File: rtl/station_pkg.sv
// rtl/station_pkg.sv - shared sizes and types for the P-WQE station slot pool
package station_pkg;
  localparam int SLOT_NUM        = 8;
  localparam int SLOT_ADDR_WIDTH = $clog2(SLOT_NUM);
  localparam int PWQE_WIDTH      = 512;
  localparam int GRP_WIDTH       = 2;
  localparam int OCC_WIDTH       = SLOT_ADDR_WIDTH + 1;

  typedef logic [SLOT_ADDR_WIDTH-1:0] slot_idx_t;
  typedef logic [GRP_WIDTH-1:0]       grp_t;
  typedef logic [PWQE_WIDTH-1:0]      pwqe_t;
  typedef logic [OCC_WIDTH-1:0]       occ_t;
endpackage

// File: rtl/station_slot_pool_if.sv
// rtl/station_slot_pool_if.sv - alloc/read/release bus of the station slot pool
interface station_slot_pool_if;
  import station_pkg::*;

  logic                          i_alloc_req;
  pwqe_t                         i_alloc_din;
  grp_t                          i_alloc_grp;
  logic                          o_alloc_gnt;
  slot_idx_t                     o_alloc_addr;
  logic                          i_rd_req;
  slot_idx_t                     i_rd_addr;
  logic                          o_rd_vld;
  pwqe_t                         o_rd_data;
  logic                          o_rd_miss;
  logic [SLOT_NUM-1:0]           o_slot_status;
  logic [SLOT_NUM*GRP_WIDTH-1:0] o_slot_grp;
  logic                          i_rel_req;
  slot_idx_t                     i_rel_addr;
  logic                          o_rel_err;
  occ_t                          o_occupancy;
  logic                          o_full;
  logic                          o_empty;

  modport master (
    output i_alloc_req, i_alloc_din, i_alloc_grp, i_rd_req, i_rd_addr, i_rel_req, i_rel_addr,
    input  o_alloc_gnt, o_alloc_addr, o_rd_vld, o_rd_data, o_rd_miss, o_slot_status,
           o_slot_grp, o_rel_err, o_occupancy, o_full, o_empty
  );

  modport slave (
    input  i_alloc_req, i_alloc_din, i_alloc_grp, i_rd_req, i_rd_addr, i_rel_req, i_rel_addr,
    output o_alloc_gnt, o_alloc_addr, o_rd_vld, o_rd_data, o_rd_miss, o_slot_status,
           o_slot_grp, o_rel_err, o_occupancy, o_full, o_empty
  );
endinterface

// File: rtl/station_slot_alloc.sv
// rtl/station_slot_alloc.sv - slot status vector, lowest-free allocator, occupancy and release check
module station_slot_alloc
  import station_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_gnt,
  output slot_idx_t           alloc_addr,
  input  logic                rel_req,
  input  slot_idx_t           rel_addr,
  output logic                rel_err,
  output logic [SLOT_NUM-1:0] status,
  output occ_t                occupancy,
  output logic                full,
  output logic                empty
);
  logic                rel_in_range;
  logic                rel_ok;
  logic [SLOT_NUM-1:0] set_mask;
  logic [SLOT_NUM-1:0] clr_mask;

  // Scan from the top so the lowest free index wins.
  always_comb begin
    alloc_addr = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (!status[i]) alloc_addr = slot_idx_t'(i);
    end
  end

  assign full         = (occupancy == OCC_WIDTH'(SLOT_NUM));
  assign empty        = (occupancy == '0);
  assign alloc_gnt    = alloc_req & ~full;
  assign rel_in_range = (32'(rel_addr) < SLOT_NUM);
  assign rel_ok       = rel_req & rel_in_range & status[rel_addr];
  assign set_mask     = alloc_gnt ? (SLOT_NUM'(1) << alloc_addr) : '0;
  assign clr_mask     = rel_ok ? (SLOT_NUM'(1) << rel_addr) : '0;

  // Grant and release always target different slots: the grant picks a free one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= '0;
      occupancy <= '0;
      rel_err   <= 1'b0;
    end else begin
      status    <= (status | set_mask) & ~clr_mask;
      occupancy <= occupancy + OCC_WIDTH'(alloc_gnt) - OCC_WIDTH'(rel_ok);
      rel_err   <= rel_req & ~rel_ok;
    end
  end
endmodule

// File: rtl/station_slot_pool.sv
// rtl/station_slot_pool.sv - P-WQE station buffer: payload/tag store, read register, allocator
module station_slot_pool
  import station_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  station_slot_pool_if.slave  bus
);
  logic [SLOT_NUM-1:0] status;
  pwqe_t               mem [SLOT_NUM];
  grp_t                tag [SLOT_NUM];
  logic                rd_in_range;
  logic                rd_vld;
  logic                rd_miss;
  pwqe_t               rd_data;

  station_slot_alloc u_alloc (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (bus.i_alloc_req),
    .alloc_gnt  (bus.o_alloc_gnt),
    .alloc_addr (bus.o_alloc_addr),
    .rel_req    (bus.i_rel_req),
    .rel_addr   (bus.i_rel_addr),
    .rel_err    (bus.o_rel_err),
    .status     (status),
    .occupancy  (bus.o_occupancy),
    .full       (bus.o_full),
    .empty      (bus.o_empty)
  );

  assign rd_in_range       = (32'(bus.i_rd_addr) < SLOT_NUM);
  assign bus.o_slot_status = status;
  assign bus.o_rd_vld      = rd_vld;
  assign bus.o_rd_miss     = rd_miss;
  assign bus.o_rd_data     = rd_data;

  for (genvar g = 0; g < SLOT_NUM; g++) begin : g_grp
    assign bus.o_slot_grp[g*GRP_WIDTH +: GRP_WIDTH] = tag[g];
  end

  always_ff @(posedge clk) begin
    if (bus.o_alloc_gnt) mem[bus.o_alloc_addr] <= bus.i_alloc_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOT_NUM; i++) tag[i] <= '0;
    end else if (bus.o_alloc_gnt) begin
      tag[bus.o_alloc_addr] <= bus.i_alloc_grp;
    end
  end

  // Read sees pre-edge memory and status, so a same-cycle alloc returns the old payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_miss <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= bus.i_rd_req;
      if (bus.i_rd_req) begin
        rd_miss <= ~(rd_in_range & status[bus.i_rd_addr]);
        rd_data <= rd_in_range ? mem[bus.i_rd_addr] : '0;
      end
    end
  end
endmodule
